// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN engine control sequencer.
// The opt encoding also selects the padding style used by the convolution.
package cnn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_CONV_DRAIN,
    S_POOL,
    S_FC,
    S_FC_DRAIN,
    S_NORM,
    S_DIV,
    S_DIV_DRAIN,
    S_ACT,
    S_OUT
  } state_e;

  localparam int N_IMG     = 48;
  localparam int N_KER     = 27;
  localparam int N_W       = 4;
  localparam int CONV_TAPS = 27;
  localparam int CONV_OPS  = 432;

  localparam logic [1:0] OPT_RELU_ZERO     = 2'd0;
  localparam logic [1:0] OPT_TANH_ZERO     = 2'd1;
  localparam logic [1:0] OPT_SIGM_REPL     = 2'd2;
  localparam logic [1:0] OPT_SOFTPLUS_REPL = 2'd3;

  function automatic logic pad_replicate(input logic [1:0] opt);
    case (opt)
      OPT_RELU_ZERO, OPT_TANH_ZERO:     pad_replicate = 1'b0;
      OPT_SIGM_REPL, OPT_SOFTPLUS_REPL: pad_replicate = 1'b1;
      default:                          pad_replicate = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cnn_conv_addr_gen.sv
// Convolution operand address generator: walks r,c (outer) and ch,kr,kc (inner),
// applying zero padding or edge replication on the 6x6 padded image.
module cnn_conv_addr_gen
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pad_repl,
  output logic [5:0] mac_a_addr,
  output logic [4:0] mac_b_addr,
  output logic       mac_pad_zero,
  output logic       mac_first,
  output logic       mac_last,
  output logic [3:0] mac_dst,
  output logic       conv_done
);

  logic [1:0] r, c, ch, kr, kc;
  logic [8:0] op;
  logic [2:0] pr, pc;
  logic [4:0] tap;

  // Padded coordinate 0..5 mapped back onto the 4x4 image, saturating at the edges.
  function automatic logic [1:0] clamp_pad(input logic [2:0] p);
    logic [2:0] q;
    q = p - 3'd1;
    if (p == 3'd0)     clamp_pad = 2'd0;
    else if (p > 3'd4) clamp_pad = 2'd3;
    else               clamp_pad = q[1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      c  <= '0;
      ch <= '0;
      kr <= '0;
      kc <= '0;
      op <= '0;
    end else if (en) begin
      op <= conv_done ? 9'd0 : op + 9'd1;
      if (kc == 2'd2) begin
        kc <= 2'd0;
        if (kr == 2'd2) begin
          kr <= 2'd0;
          if (ch == 2'd2) begin
            ch <= 2'd0;
            if (c == 2'd3) begin
              c <= 2'd0;
              r <= r + 2'd1;
            end else begin
              c <= c + 2'd1;
            end
          end else begin
            ch <= ch + 2'd1;
          end
        end else begin
          kr <= kr + 2'd1;
        end
      end else begin
        kc <= kc + 2'd1;
      end
    end
  end

  always_comb begin
    pr           = {1'b0, r} + {1'b0, kr};
    pc           = {1'b0, c} + {1'b0, kc};
    tap          = 5'(ch) * 5'd9 + 5'(kr) * 5'd3 + 5'(kc);
    mac_pad_zero = !pad_repl &&
                   (pr == 3'd0 || pr == 3'd5 || pc == 3'd0 || pc == 3'd5);
    mac_a_addr   = mac_pad_zero ? 6'd0 : {ch, clamp_pad(pr), clamp_pad(pc)};
    mac_b_addr   = tap;
    mac_first    = (tap == 5'd0);
    mac_last     = (tap == 5'(CONV_TAPS - 1));
    mac_dst      = {r, c};
    conv_done    = (op == 9'(CONV_OPS - 1));
  end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Control sequencer for the single-pattern CNN engine: load burst, then a fixed
// schedule of conv/pool/FC/norm/div/activation/output strobes. Outputs are registered.
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int MAC_LAT = 3,
  parameter int DIV_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] opt,
  input  logic       act_ack,
  output logic [1:0] opt_q,
  output logic       ld_img_we,
  output logic [5:0] ld_img_addr,
  output logic       ld_ker_we,
  output logic [4:0] ld_ker_addr,
  output logic       ld_w_we,
  output logic [1:0] ld_w_addr,
  output logic       mac_issue,
  output logic       mac_sel,
  output logic [5:0] mac_a_addr,
  output logic [4:0] mac_b_addr,
  output logic       mac_pad_zero,
  output logic       mac_first,
  output logic       mac_last,
  output logic [3:0] mac_dst,
  output logic       pool_issue,
  output logic [1:0] pool_idx,
  output logic       norm_start,
  output logic       div_issue,
  output logic [1:0] div_idx,
  output logic       act_req,
  output logic [1:0] act_idx,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       busy
);

  state_e     state, state_next;
  logic [5:0] ld_cnt;
  logic [3:0] step;
  logic       load_wr, ker_wr, w_wr, act_fire;

  logic [5:0] cg_a;
  logic [4:0] cg_b;
  logic       cg_pad, cg_first, cg_last, conv_done;
  logic [3:0] cg_dst;

  logic [5:0] a_d;
  logic [4:0] b_d;
  logic       pad_d, first_d, last_d;
  logic [3:0] dst_d;

  assign load_wr  = in_valid && (state == S_IDLE || state == S_LOAD);
  assign ker_wr   = load_wr && (ld_cnt < 6'(N_KER));
  assign w_wr     = load_wr && (ld_cnt < 6'(N_W));
  // Only an ack that lands on a live request advances the activation index.
  assign act_fire = act_req && act_ack;

  cnn_conv_addr_gen u_conv_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .en           (state == S_CONV),
    .pad_repl     (pad_replicate(opt_q)),
    .mac_a_addr   (cg_a),
    .mac_b_addr   (cg_b),
    .mac_pad_zero (cg_pad),
    .mac_first    (cg_first),
    .mac_last     (cg_last),
    .mac_dst      (cg_dst),
    .conv_done    (conv_done)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (in_valid) state_next = S_LOAD;
      S_LOAD:       if (in_valid && ld_cnt == 6'(N_IMG - 1)) state_next = S_CONV;
      S_CONV:       if (conv_done) state_next = S_CONV_DRAIN;
      S_CONV_DRAIN: if (step == 4'(MAC_LAT - 1)) state_next = S_POOL;
      S_POOL:       if (step == 4'd3) state_next = S_FC;
      S_FC:         if (step == 4'd7) state_next = S_FC_DRAIN;
      S_FC_DRAIN:   if (step == 4'(MAC_LAT - 1)) state_next = S_NORM;
      S_NORM:       state_next = S_DIV;
      S_DIV:        if (step == 4'd3) state_next = S_DIV_DRAIN;
      S_DIV_DRAIN:  if (step == 4'(DIV_LAT - 1)) state_next = S_ACT;
      S_ACT:        if (act_fire && act_idx == 2'd3) state_next = S_OUT;
      S_OUT:        if (step == 4'd3) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // FC op index o*2+k lives in step: o = step[2:1] = {i,j}, k = step[0].
  always_comb begin
    a_d     = '0;
    b_d     = '0;
    pad_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    dst_d   = '0;
    if (state == S_CONV) begin
      a_d     = cg_a;
      b_d     = cg_b;
      pad_d   = cg_pad;
      first_d = cg_first;
      last_d  = cg_last;
      dst_d   = cg_dst;
    end else if (state == S_FC) begin
      a_d     = {4'd0, step[2], step[0]};
      b_d     = {3'd0, step[0], step[1]};
      dst_d   = {2'd0, step[2:1]};
      first_d = !step[0];
      last_d  = step[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      step   <= '0;
      ld_cnt <= '0;
    end else begin
      state <= state_next;
      step  <= (state_next != state) ? 4'd0 : step + 4'd1;
      if (load_wr) ld_cnt <= (ld_cnt == 6'(N_IMG - 1)) ? 6'd0 : ld_cnt + 6'd1;
    end
  end

  // Output register stage: every strobe lags the state that produced it by one cycle,
  // except act_req which is aimed at the state being entered so a request and its ack share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_q        <= '0;
      ld_img_we    <= 1'b0;
      ld_img_addr  <= '0;
      ld_ker_we    <= 1'b0;
      ld_ker_addr  <= '0;
      ld_w_we      <= 1'b0;
      ld_w_addr    <= '0;
      mac_issue    <= 1'b0;
      mac_sel      <= 1'b0;
      mac_a_addr   <= '0;
      mac_b_addr   <= '0;
      mac_pad_zero <= 1'b0;
      mac_first    <= 1'b0;
      mac_last     <= 1'b0;
      mac_dst      <= '0;
      pool_issue   <= 1'b0;
      pool_idx     <= '0;
      norm_start   <= 1'b0;
      div_issue    <= 1'b0;
      div_idx      <= '0;
      act_req      <= 1'b0;
      act_idx      <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      busy         <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) opt_q <= opt;
      ld_img_we    <= load_wr;
      ld_img_addr  <= load_wr ? ld_cnt : 6'd0;
      ld_ker_we    <= ker_wr;
      ld_ker_addr  <= ker_wr ? ld_cnt[4:0] : 5'd0;
      ld_w_we      <= w_wr;
      ld_w_addr    <= w_wr ? ld_cnt[1:0] : 2'd0;
      mac_issue    <= (state == S_CONV) || (state == S_FC);
      mac_sel      <= (state == S_FC);
      mac_a_addr   <= a_d;
      mac_b_addr   <= b_d;
      mac_pad_zero <= pad_d;
      mac_first    <= first_d;
      mac_last     <= last_d;
      mac_dst      <= dst_d;
      pool_issue   <= (state == S_POOL);
      pool_idx     <= (state == S_POOL) ? step[1:0] : 2'd0;
      norm_start   <= (state == S_NORM);
      div_issue    <= (state == S_DIV);
      div_idx      <= (state == S_DIV) ? step[1:0] : 2'd0;
      act_req      <= (state_next == S_ACT);
      if (act_fire) act_idx <= act_idx + 2'd1;
      out_valid    <= (state == S_OUT);
      out_idx      <= (state == S_OUT) ? step[1:0] : 2'd0;
      busy         <= (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Directed bench for cnn_seq_ctrl: load bursts, schedule timing relative to t0,
// conv/FC operand sequences, activation handshake, and mid-run reset.
module tb_cnn_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] opt;
  logic       act_ack = 1'b0;
  logic [1:0] opt_q;
  logic       ld_img_we, ld_ker_we, ld_w_we;
  logic [5:0] ld_img_addr;
  logic [4:0] ld_ker_addr;
  logic [1:0] ld_w_addr;
  logic       mac_issue, mac_sel, mac_pad_zero, mac_first, mac_last;
  logic [5:0] mac_a_addr;
  logic [4:0] mac_b_addr;
  logic [3:0] mac_dst;
  logic       pool_issue, norm_start, div_issue, act_req, out_valid, busy;
  logic [1:0] pool_idx, div_idx, act_idx, out_idx;

  cnn_seq_ctrl #(.MAC_LAT(3), .DIV_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opt(opt), .act_ack(act_ack),
    .opt_q(opt_q),
    .ld_img_we(ld_img_we), .ld_img_addr(ld_img_addr),
    .ld_ker_we(ld_ker_we), .ld_ker_addr(ld_ker_addr),
    .ld_w_we(ld_w_we), .ld_w_addr(ld_w_addr),
    .mac_issue(mac_issue), .mac_sel(mac_sel), .mac_a_addr(mac_a_addr),
    .mac_b_addr(mac_b_addr), .mac_pad_zero(mac_pad_zero), .mac_first(mac_first),
    .mac_last(mac_last), .mac_dst(mac_dst),
    .pool_issue(pool_issue), .pool_idx(pool_idx), .norm_start(norm_start),
    .div_issue(div_issue), .div_idx(div_idx),
    .act_req(act_req), .act_idx(act_idx),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [63:0] all_out;
  assign all_out = {12'd0, opt_q, ld_img_we, ld_img_addr, ld_ker_we, ld_ker_addr,
                    ld_w_we, ld_w_addr, mac_issue, mac_sel, mac_a_addr, mac_b_addr,
                    mac_pad_zero, mac_first, mac_last, mac_dst, pool_issue, pool_idx,
                    norm_start, div_issue, div_idx, act_req, act_idx, out_valid,
                    out_idx, busy};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor state, written only by the negedge monitor.
  logic       mon_clr = 1'b1;
  int         ack_dly = 0;
  logic [5:0] cv_a [432];
  logic [4:0] cv_b [432];
  logic       cv_pad [432];
  logic       cv_first [432];
  logic       cv_last [432];
  logic [3:0] cv_dst [432];
  logic [13:0] fc_rec [8];
  int n_img, n_ker, n_w, ld_err, t0, n_conv, first_mac, last_conv, n_fc;
  int n_pool, first_pool, pool_err, n_norm, first_norm, n_div, first_div, div_err;
  int first_req, hold_err, w_tot, wcnt, n_out, first_out, last_out, out_err, busy_fall;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_busy = 1'b0;
  logic [1:0] prev_idx = 2'd0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_img = 0; n_ker = 0; n_w = 0; ld_err = 0; t0 = -1000;
      n_conv = 0; first_mac = -1; last_conv = -1; n_fc = 0;
      n_pool = 0; first_pool = -1; pool_err = 0; n_norm = 0; first_norm = -1;
      n_div = 0; first_div = -1; div_err = 0; first_req = -1; hold_err = 0;
      w_tot = 0; wcnt = 0; n_out = 0; first_out = -1; last_out = -1; out_err = 0;
      busy_fall = -1;
    end else begin
      if (ld_img_we) begin
        if (ld_img_addr != 6'(n_img)) ld_err++;
        if (ld_img_addr == 6'd47) t0 = cyc;
        n_img++;
      end
      if (ld_ker_we) begin
        if (ld_ker_addr != 5'(n_ker)) ld_err++;
        n_ker++;
      end
      if (ld_w_we) begin
        if (ld_w_addr != 2'(n_w)) ld_err++;
        n_w++;
      end
      if (mac_issue && !mac_sel) begin
        if (n_conv == 0) first_mac = cyc;
        if (n_conv < 432) begin
          cv_a[n_conv] = mac_a_addr; cv_b[n_conv] = mac_b_addr;
          cv_pad[n_conv] = mac_pad_zero; cv_first[n_conv] = mac_first;
          cv_last[n_conv] = mac_last; cv_dst[n_conv] = mac_dst;
        end
        last_conv = cyc;
        n_conv++;
      end
      if (mac_issue && mac_sel) begin
        if (n_fc < 8)
          fc_rec[n_fc] = {mac_a_addr[1:0], mac_b_addr[1:0], mac_dst, mac_pad_zero,
                          mac_first, mac_last, 3'd0};
        n_fc++;
      end
      if (pool_issue) begin
        if (n_pool == 0) first_pool = cyc;
        if (pool_idx != 2'(n_pool)) pool_err++;
        n_pool++;
      end
      if (norm_start) begin
        if (n_norm == 0) first_norm = cyc;
        n_norm++;
      end
      if (div_issue) begin
        if (n_div == 0) first_div = cyc;
        if (div_idx != 2'(n_div)) div_err++;
        n_div++;
      end
      if (act_req && first_req < 0) first_req = cyc;
      if (act_req && prev_req && !prev_ack && act_idx != prev_idx) hold_err++;
      if (out_valid) begin
        if (n_out == 0) first_out = cyc;
        if (out_idx != 2'(n_out)) out_err++;
        last_out = cyc;
        n_out++;
      end
      if (prev_busy && !busy) busy_fall = cyc;
    end
    // Activation unit model: tied high, or acks after ack_dly waiting cycles.
    if (ack_dly == 0) act_ack = 1'b1;
    else if (act_req) begin
      if (wcnt >= ack_dly) begin act_ack = 1'b1; wcnt = 0; end
      else begin act_ack = 1'b0; wcnt++; end
    end else begin
      act_ack = 1'b0; wcnt = 0;
    end
    if (act_req && !act_ack) w_tot++;
    prev_req = act_req; prev_ack = act_ack; prev_idx = act_idx; prev_busy = busy;
  end

  function automatic logic [17:0] conv_exp(input int n, input logic [1:0] o);
    int rc, tap, r, c, ch, kr, kc, pr, pc, ar, ac, a, b;
    logic pad;
    rc = n / 27; tap = n % 27;
    r = rc / 4; c = rc % 4;
    ch = tap / 9; kr = (tap % 9) / 3; kc = tap % 3;
    pr = r + kr; pc = c + kc;
    pad = (o[1] == 1'b0) && (pr == 0 || pr == 5 || pc == 0 || pc == 5);
    ar = pr - 1; if (ar < 0) ar = 0; if (ar > 3) ar = 3;
    ac = pc - 1; if (ac < 0) ac = 0; if (ac > 3) ac = 3;
    a = ch * 16 + ar * 4 + ac;
    b = ch * 9 + kr * 3 + kc;
    return {6'(a), 5'(b), pad, (tap == 0), (tap == 26), 4'(r * 4 + c)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_burst(input logic [1:0] o, input int gap_after, input int gap_len);
    for (int k = 0; k < 48; k++) begin
      in_valid = 1'b1;
      opt = (k == 0) ? o : ~o;
      tick(1);
      if (k == gap_after) begin
        in_valid = 1'b0;
        tick(gap_len);
      end
    end
    in_valid = 1'b0;
    opt = 2'd0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!(n_out >= 4 && !busy) && k < 1500) begin
      tick(1);
      k++;
    end
    check({tag, "_finish_in_budget"}, (k < 1500), 1);
    tick(2);
  endtask

  task automatic check_run(input string tag, input logic [1:0] o, input int out_off,
                           input int w_exp);
    int e;
    logic [17:0] x, g;
    int on, oi, oj, ok;
    check({tag, "_img_writes"}, n_img, 48);
    check({tag, "_ker_writes"}, n_ker, 27);
    check({tag, "_w_writes"}, n_w, 4);
    check({tag, "_ld_addr_errs"}, ld_err, 0);
    check({tag, "_opt_q"}, opt_q, o);
    check({tag, "_first_mac"}, first_mac - t0, 1);
    check({tag, "_last_conv"}, last_conv - t0, 432);
    check({tag, "_conv_count"}, n_conv, 432);
    e = 0;
    for (int n = 0; n < 432; n++) begin
      x = conv_exp(n, o);
      g = {cv_a[n], cv_b[n], cv_pad[n], cv_first[n], cv_last[n], cv_dst[n]};
      if (g[11:0] != x[11:0] || (!x[6] && g[17:12] != x[17:12])) e++;
    end
    check({tag, "_conv_sched_errs"}, e, 0);
    check({tag, "_fc_count"}, n_fc, 8);
    e = 0;
    for (int n = 0; n < 8; n++) begin
      on = n / 2; ok = n % 2; oi = on / 2; oj = on % 2;
      if (fc_rec[n] != {2'(oi * 2 + ok), 2'(ok * 2 + oj), 4'(on), 1'b0,
                        (ok == 0), (ok == 1), 3'd0}) e++;
    end
    check({tag, "_fc_sched_errs"}, e, 0);
    check({tag, "_first_pool"}, first_pool - t0, 436);
    check({tag, "_pool_seq"}, {n_pool, pool_err}, {32'd4, 32'd0});
    check({tag, "_norm"}, {first_norm - t0, n_norm}, {32'd451, 32'd1});
    check({tag, "_first_div"}, first_div - t0, 452);
    check({tag, "_div_seq"}, {n_div, div_err}, {32'd4, 32'd0});
    check({tag, "_first_req"}, first_req - t0, 457);
    check({tag, "_act_wait"}, w_tot, w_exp);
    check({tag, "_act_idx_hold"}, hold_err, 0);
    check({tag, "_first_out"}, first_out - t0, out_off);
    check({tag, "_out_beats"}, n_out, 4);
    check({tag, "_out_consecutive"}, last_out - first_out, 3);
    check({tag, "_out_idx_seq"}, out_err, 0);
    check({tag, "_busy_fall"}, busy_fall - first_out, 4);
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; opt = 2'd0; ack_dly = 0;
    tick(3);
    check("rst_outputs_zero", all_out, 0);
    rst = 1'b0;
    tick(2);
    check("idle_outputs_zero", all_out, 0);

    // opt=0, contiguous burst, ack tied high
    mon_clear();
    do_burst(2'd0, -1, 0);
    wait_done("a");
    check("a_i0_pad", cv_pad[0], 1);
    check("a_i4_a", cv_a[4], 0);
    check("a_i4_pad", cv_pad[4], 0);
    check("a_i4_b", cv_b[4], 4);
    check_run("a", 2'd0, 462, 0);

    // opt=2, gap of 3 after count 10, stray in_valid during CONV
    mon_clear();
    do_burst(2'd2, 10, 3);
    tick(40);
    in_valid = 1'b1;
    tick(3);
    in_valid = 1'b0;
    wait_done("b");
    check("b_i0_pad", cv_pad[0], 0);
    check("b_i0_a", cv_a[0], 0);
    check("b_i431_a", cv_a[431], 47);
    check("b_i431_b", cv_b[431], 26);
    check("b_i431_dst", cv_dst[431], 15);
    check("b_i431_last", cv_last[431], 1);
    check_run("b", 2'd2, 462, 0);

    // opt=3, activation ack after 5 waiting cycles per request
    ack_dly = 5;
    mon_clear();
    do_burst(2'd3, -1, 0);
    wait_done("c");
    check_run("c", 2'd3, 482, 20);
    ack_dly = 0;

    // reset during FC, then a fresh burst
    mon_clear();
    do_burst(2'd1, -1, 0);
    k = 0;
    while (!(mac_issue && mac_sel) && k < 1000) begin
      tick(1);
      k++;
    end
    check("d_reached_fc", (k < 1000), 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("d_busy_after_rst", busy, 0);
    check("d_outputs_after_rst", all_out, 0);
    mon_clear();
    tick(600);
    check("d_no_out_after_abort", n_out, 0);
    check("d_no_issue_after_abort", n_conv + n_fc + n_pool, 0);
    mon_clear();
    do_burst(2'd1, -1, 0);
    wait_done("e");
    check_run("e", 2'd1, 462, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cnn_seq_ctrl.md
# cnn_seq_ctrl

Control sequencer for the single-pattern CNN engine: 3×4×4 image, 3×3×3 kernel, 2×2 pool, 2×2 fully connected layer, min-max normalisation, four selectable activations and a 4-word output. It counts the 48-cycle input burst and generates buffer write strobes. It then schedules every datapath operation in a fixed order onto one shared FP multiply-accumulate unit, one divider and one variable-latency activation unit. It holds no FP arithmetic itself; it emits only addresses, enables and phase strobes.

## Interface
- MAC_LAT, 3: cycles from `mac_issue` until the accumulated result is written to its destination register.
- DIV_LAT, 2: cycles from `div_issue` until the quotient is written.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input burst qualifier.
- opt  in  2  activation/padding select; sampled only on the first `in_valid` cycle.
- act_ack  in  1  activation unit accepted the request and result is written.
- opt_q  out  2  latched opt.
- ld_img_we / ld_img_addr  out  1/6  image write, address = load count 0..47.
- ld_ker_we / ld_ker_addr  out  1/5  kernel write while count<27.
- ld_w_we / ld_w_addr  out  1/2  weight write while count<4.
- mac_issue  out  1  one MAC op this cycle.
- mac_sel  out  1  0 = conv (image × kernel), 1 = FC (pool × weight).
- mac_a_addr  out  6  image address (conv) or pool index 0..3 (FC).
- mac_b_addr  out  5  kernel address (conv) or weight index 0..3 (FC).
- mac_pad_zero  out  1  force the A operand to +0.
- mac_first / mac_last  out  1/1  first/last term of the accumulation.
- mac_dst  out  4  feature index r*4+c (conv) or L index 0..3 (FC).
- pool_issue / pool_idx  out  1/2  4-way max of window idx.
- norm_start  out  1  latch L_min and L_range.
- div_issue / div_idx  out  1/2  compute R[idx].
- act_req / act_idx  out  1/2  activation request.
- out_valid / out_idx  out  1/2  output word strobe.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, CONV, CONV_DRAIN, POOL, FC, FC_DRAIN, NORM, DIV, DIV_DRAIN, ACT, OUT.
- IDLE → LOAD on `in_valid`. That cycle latches `opt_q` and writes count 0.
- LOAD: each `in_valid` cycle writes at the current count, then increments it. Gaps in `in_valid` pause the count. After count 47 is written, go to CONV.
- CONV: 432 issues, one per cycle. Loop order is r, c (outer) then ch, kr, kc (inner). Issue n = (r*4+c)*27 + ch*9+kr*3+kc.
  - Padded coordinates: pr = r+kr, pc = c+kc (0..5).
  - opt_q[1]=0 and (pr or pc ∈ {0,5}) → mac_pad_zero=1.
  - Otherwise mac_a_addr = ch*16 + clamp(pr−1,0,3)*4 + clamp(pc−1,0,3).
  - mac_b_addr = ch*9+kr*3+kc. mac_first at tap 0, mac_last at tap 26.
- CONV_DRAIN: MAC_LAT cycles, then POOL.
- POOL: 4 cycles, pool_idx 0..3.
- FC: 8 issues, output o = i*2+j, k = 0..1, mac_a_addr = i*2+k, mac_b_addr = k*2+j, mac_dst = o, mac_first at k=0, mac_last at k=1.
- FC_DRAIN: MAC_LAT cycles.
- NORM: 1 cycle of norm_start.
- DIV: 4 cycles, div_idx 0..3.
- DIV_DRAIN: DIV_LAT cycles.
- ACT: act_req=1 with act_idx held until act_ack. Then act_idx increments, and the next request is asserted in the following cycle. After ack of idx 3, go to OUT.
- OUT: 4 cycles, out_idx 0..3, then IDLE.
- `in_valid` outside IDLE/LOAD is ignored.
- `act_ack` without `act_req` is ignored.

## Timing
- Reset: state IDLE, all counters 0. Every output is 0, including opt_q.
- Reset mid-operation aborts immediately. No partial out_valid follows.
- All outputs are registered from state/counters. No input→output combinational path.
- t0 = cycle carrying load count 47.
- First mac_issue is at t0+1. Last conv issue is at t0+432.
- First out_valid = t0 + 454 + 2*MAC_LAT + DIV_LAT + W, where W = total act wait cycles. With defaults and act_ack in the request cycle: t0+462.
- out_valid is high exactly 4 consecutive cycles. busy falls the cycle after out_idx 3.
- A new burst is accepted in the first IDLE cycle.

## Structure
- Package cnn_pkg holds:
  - state enum
  - N_IMG=48, N_KER=27, N_W=4, CONV_TAPS=27, CONV_OPS=432
  - opt encodings: 0 ReLU/zero-pad, 1 tanh/zero-pad, 2 sigmoid/replicate-pad, 3 softplus/replicate-pad
- Sub-module cnn_conv_addr_gen: r/c/ch/kr/kc counters, padding and clamp logic. Outputs mac_a_addr, mac_b_addr, mac_pad_zero, mac_first, mac_last, mac_dst, conv_done.

## Test plan
- opt=0 burst, CONV issue 0 → mac_pad_zero=1. Issue 4 (kr=1,kc=1) → mac_a_addr=0, pad 0, mac_b_addr=4.
- opt=2, CONV issue 0 → mac_pad_zero=0, mac_a_addr=0. Issue 431 → mac_a_addr=47, mac_b_addr=26, mac_dst=15, mac_last=1.
- 48-cycle burst with a 3-cycle in_valid gap after count 10 → 48 image, 27 kernel and 4 weight writes. first out_valid = t0+462 when act_ack is tied high.
- act_ack delayed 5 cycles per request → act_idx held during each wait, out_valid at t0+482, 4 beats with out_idx 0,1,2,3.
- rst asserted during FC → next cycle busy=0 and all outputs 0. A fresh burst then completes normally.
- in_valid pulsed during CONV → no ld_*_we, and the schedule is unchanged.
